// File: rtl/keypad_debounce_encoder_if.sv
// Keypad encoder port bundle: raw keys and enable in, debounced code out.
// The design attaches as slave; whatever drives the key lines is master.
interface keypad_debounce_encoder_if #(
    parameter int NUM_KEYS = 10,
    parameter int CODE_W   = 4
);
    logic [NUM_KEYS-1:0] keyboard;
    logic                enablen;
    logic [CODE_W-1:0]   code;
    logic                valid;
    logic                held;
    logic                multi;

    modport master (
        output keyboard, enablen,
        input  code, valid, held, multi
    );

    modport slave (
        input  keyboard, enablen,
        output code, valid, held, multi
    );
endinterface

// File: rtl/keypad_debounce_encoder.sv
// Synchronised, debounced priority keypad encoder with one valid per press.
// Define KEYPAD_REPEAT_EN to add auto-repeat strobes while a key stays down.
module keypad_debounce_encoder #(
    parameter int NUM_KEYS        = 10,
    parameter int CODE_W          = 4,
    parameter int DEBOUNCE_CYCLES = 4
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 32,
    parameter int REPEAT_PERIOD   = 8
`endif
) (
    input logic                      clock,
    input logic                      reset,
    keypad_debounce_encoder_if.slave kp
);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    localparam logic [NUM_KEYS-1:0] ONE = NUM_KEYS'(1);
    localparam logic [7:0]          DC  = 8'(DEBOUNCE_CYCLES);

    state_t              state;
    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] ks;
    logic [CODE_W-1:0]   pcode;
    logic [CODE_W-1:0]   cand;
    logic [CODE_W-1:0]   code;
    logic [7:0]          cnt;
    logic [7:0]          cnt_inc;
    logic                nz;
    logic                valid;
    logic                held;
    logic                multi;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [15:0] RD = 16'(REPEAT_DELAY);
    localparam logic [15:0] RP = 16'(REPEAT_PERIOD);
    // Down-counter: a strobe fires when it expires, then it reloads the period.
    logic [15:0] rcnt;
`endif

    always_comb begin
        pcode = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (ks[i]) pcode = CODE_W'(i);
        end
    end

    assign nz      = |ks;
    assign cnt_inc = cnt + 8'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sync1 <= '0;
            ks    <= '0;
            cand  <= '0;
            code  <= '0;
            cnt   <= '0;
            valid <= 1'b0;
            held  <= 1'b0;
            multi <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rcnt  <= '0;
`endif
        end else begin
            sync1 <= kp.keyboard;
            ks    <= sync1;
            // Clearing the lowest set bit leaves something iff 2+ bits are set.
            multi <= |(ks & (ks - ONE));
            valid <= 1'b0;
            if (kp.enablen) begin
                state <= IDLE;
                cnt   <= '0;
                held  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (nz) begin
                            cand <= pcode;
                            cnt  <= 8'd1;
                            if (DC == 8'd1) begin
                                state <= PRESSED;
                                code  <= pcode;
                                valid <= 1'b1;
                                held  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                                rcnt  <= RD;
`endif
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (!nz) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (pcode != cand) begin
                            cand <= pcode;
                            cnt  <= 8'd1;
                        end else begin
                            cnt <= cnt_inc;
                            if (cnt_inc == DC) begin
                                state <= PRESSED;
                                code  <= cand;
                                valid <= 1'b1;
                                held  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                                rcnt  <= RD;
`endif
                            end
                        end
                    end
                    PRESSED: begin
                        if (!nz) begin
                            cnt <= 8'd1;
                            if (DC == 8'd1) begin
                                state <= IDLE;
                                held  <= 1'b0;
                            end else begin
                                state <= RELEASE;
                            end
                        end
`ifdef KEYPAD_REPEAT_EN
                        else if (rcnt == 16'd1) begin
                            valid <= 1'b1;
                            rcnt  <= RP;
                        end else begin
                            rcnt <= rcnt - 16'd1;
                        end
`endif
                    end
                    RELEASE: begin
                        if (nz) begin
                            state <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
                            rcnt  <= RD;
`endif
                        end else begin
                            cnt <= cnt_inc;
                            if (cnt_inc == DC) begin
                                state <= IDLE;
                                held  <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign kp.code  = code;
    assign kp.valid = valid;
    assign kp.held  = held;
    assign kp.multi = multi;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Directed and random stimulus against a run-length reference model of
// the keypad encoder; every cycle is compared after the clock edge.
module tb_keypad_debounce_encoder;

    localparam int NK = 10;
    localparam int CW = 4;
    localparam int DC = 4;
`ifdef KEYPAD_REPEAT_EN
    localparam int RD = 32;
    localparam int RP = 8;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    keypad_debounce_encoder_if #(.NUM_KEYS(NK), .CODE_W(CW)) kp ();

    keypad_debounce_encoder #(
        .NUM_KEYS       (NK),
        .CODE_W         (CW),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .kp   (kp)
    );

    always #5 clock = ~clock;

    // Reference model state: key history plus run lengths of the seen samples.
    logic [NK-1:0] kq[$];
    bit            m_held;
    bit            m_valid;
    bit            m_multi;
    logic [CW-1:0] m_code;
    int            nzrun;
    int            zrun;
    int            age;
    int            lastpc;
    int            cyc;
    int            valids;

    function automatic int penc(input logic [NK-1:0] v);
        int r = 0;
        for (int i = 0; i < NK; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        kq = {};
        kq.push_back('0);
        kq.push_back('0);
        m_held  = 0;
        m_valid = 0;
        m_multi = 0;
        m_code  = '0;
        nzrun   = 0;
        zrun    = 0;
        age     = 0;
        lastpc  = 0;
    endtask

    task automatic model_edge(input logic [NK-1:0] k, input logic en);
        logic [NK-1:0] s;
        int pc;
        int zprev;
        s = kq.pop_front();
        kq.push_back(k);
        m_valid = 0;
        m_multi = ($countones(s) > 1);
        if (en) begin
            m_held = 0;
            nzrun  = 0;
            zrun   = 0;
            age    = 0;
        end else if (s != '0) begin
            zprev  = zrun;
            zrun   = 0;
            pc     = penc(s);
            nzrun  = (nzrun > 0 && pc == lastpc) ? nzrun + 1 : 1;
            lastpc = pc;
            if (!m_held) begin
                if (nzrun == DC) begin
                    m_held  = 1;
                    m_code  = CW'(pc);
                    m_valid = 1;
                    age     = 0;
                end
            end
`ifdef KEYPAD_REPEAT_EN
            else begin
                age = (zprev > 0) ? 0 : age + 1;
                if (age == RD || (age > RD && (age - RD) % RP == 0))
                    m_valid = 1;
            end
`endif
        end else begin
            nzrun = 0;
            if (m_held) begin
                zrun++;
                if (zrun == DC) begin
                    m_held = 0;
                    zrun   = 0;
                end
            end else begin
                zrun = 0;
            end
        end
    endtask

    task automatic step(input logic [NK-1:0] k, input logic en);
        kp.keyboard = k;
        kp.enablen  = en;
        @(posedge clock);
        model_edge(k, en);
        cyc++;
        #1;
        if (kp.valid) valids++;
        chk("valid", 32'(kp.valid), 32'(m_valid));
        chk("held",  32'(kp.held),  32'(m_held));
        chk("multi", 32'(kp.multi), 32'(m_multi));
        chk("code",  32'(kp.code),  32'(m_code));
    endtask

    initial begin
        int first;
        int rel;
        int v0;
        int offs[$];
        logic [NK-1:0] k;
        int len;
        logic en;

        cyc    = 0;
        valids = 0;
        kp.keyboard = '0;
        kp.enablen  = 1'b0;
        model_reset();
        #12;
        chk("rst_valid", 32'(kp.valid), 0);
        chk("rst_held",  32'(kp.held),  0);
        chk("rst_multi", 32'(kp.multi), 0);
        chk("rst_code",  32'(kp.code),  0);
        reset = 1'b0;

        // Single key 3: latency and release timing
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            step(10'b0000001000, 1'b0);
            if (kp.valid && first < 0) first = i;
        end
        chk("t1_latency", 32'(first), 6);
        chk("t1_code", 32'(kp.code), 3);
        chk("t1_held", 32'(kp.held), 1);
        rel = -1;
        for (int i = 1; i <= 10; i++) begin
            step('0, 1'b0);
            if (!kp.held && rel < 0) rel = i;
        end
        chk("t1_release", 32'(rel), 6);

        // Bounce on key 5
        v0 = valids;
        for (int i = 0; i < 10; i++)
            step(((i / 2) % 2 == 0) ? 10'b0000100000 : 10'b0, 1'b0);
        chk("t2_bounce_quiet", 32'(valids - v0), 0);
        repeat (12) step(10'b0000100000, 1'b0);
        chk("t2_one_valid", 32'(valids - v0), 1);
        chk("t2_code", 32'(kp.code), 5);
        repeat (10) step('0, 1'b0);

        // Two keys: multi lags by 3 edges, highest index wins
        step(10'b1000000010, 1'b0);
        step(10'b1000000010, 1'b0);
        chk("t3_multi_e2", 32'(kp.multi), 0);
        step(10'b1000000010, 1'b0);
        chk("t3_multi_e3", 32'(kp.multi), 1);
        repeat (8) step(10'b1000000010, 1'b0);
        chk("t3_code", 32'(kp.code), 9);
        repeat (10) step('0, 1'b0);

        // Disabled then enabled mid-press on key 7
        v0 = valids;
        repeat (10) step(10'b0010000000, 1'b1);
        chk("t4_no_valid", 32'(valids - v0), 0);
        chk("t4_held", 32'(kp.held), 0);
        first = -1;
        for (int i = 1; i <= 10; i++) begin
            step(10'b0010000000, 1'b0);
            if (kp.valid && first < 0) first = i;
        end
        chk("t4_latency", 32'(first), 4);
        chk("t4_code", 32'(kp.code), 7);
        repeat (10) step('0, 1'b0);

        // Asynchronous reset while key 2 is pressed
        repeat (10) step(10'b0000000100, 1'b0);
        chk("t5_code_pre", 32'(kp.code), 2);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(kp.valid), 0);
        chk("t5_rst_held",  32'(kp.held),  0);
        chk("t5_rst_multi", 32'(kp.multi), 0);
        chk("t5_rst_code",  32'(kp.code),  0);
        model_reset();
        @(posedge clock);
        #1 reset = 1'b0;
        first = -1;
        for (int i = 1; i <= 10; i++) begin
            step(10'b0000000100, 1'b0);
            if (kp.valid && first < 0) first = i;
        end
        chk("t5_latency", 32'(first), 6);
        chk("t5_code", 32'(kp.code), 2);
        repeat (10) step('0, 1'b0);

        // Random key patterns, durations and enable drops
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0:       k = '0;
                1, 2:    k = NK'(1) << $urandom_range(0, NK - 1);
                3:       k = (NK'(1) << $urandom_range(0, NK - 1)) |
                             (NK'(1) << $urandom_range(0, NK - 1));
                default: k = NK'($urandom);
            endcase
            en  = ($urandom_range(0, 7) == 0);
            len = $urandom_range(1, 12);
            repeat (len) step(k, en);
        end
        repeat (3) step('0, 1'b1);
        repeat (3) step('0, 1'b0);

`ifdef KEYPAD_REPEAT_EN
        // Auto-repeat on key 1 held through several periods
        offs = {};
        for (int i = 1; i <= 66; i++) begin
            step(10'b0000000010, 1'b0);
            if (kp.valid) offs.push_back(i);
        end
        chk("t6_count", 32'(offs.size()), 5);
        if (offs.size() == 5) begin
            chk("t6_first", 32'(offs[0]), 6);
            chk("t6_rep1", 32'(offs[1] - offs[0]), 32);
            chk("t6_rep2", 32'(offs[2] - offs[0]), 40);
            chk("t6_rep3", 32'(offs[3] - offs[0]), 48);
            chk("t6_rep4", 32'(offs[4] - offs[0]), 56);
        end
        chk("t6_code", 32'(kp.code), 1);
        repeat (8) step('0, 1'b0);
`else
        offs = {};
        for (int i = 1; i <= 66; i++) begin
            step(10'b0000000010, 1'b0);
            if (kp.valid) offs.push_back(i);
        end
        chk("t6_single", 32'(offs.size()), 1);
        chk("t6_code", 32'(kp.code), 1);
        repeat (8) step('0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_debounce_encoder.md
# keypad_debounce_encoder

Clocked, parametrised successor to the combinational keypad encoder in the microwave controller's clock-entry path. It synchronises a one-hot key vector, debounces it, priority-encodes it to a binary/BCD code and emits exactly one `valid` strobe per debounced press. It sits between the raw keypad pins and the digit-entry shift logic, which consumes `code` on `valid`.

## Interface
- `NUM_KEYS`, default 10: width of the key vector; key index i encodes to code value i.
- `CODE_W`, default 4: width of `code`; must satisfy 2^CODE_W >= NUM_KEYS.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples required for press and for release; range 1..255.
- `REPEAT_DELAY`, default 32: cycles held in PRESSED before the first auto-repeat. Used only with `KEYPAD_REPEAT_EN`.
- `REPEAT_PERIOD`, default 8: cycles between auto-repeat strobes. Used only with `KEYPAD_REPEAT_EN`.

Ports:
- `clock` in 1: single clock; all state is updated on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `keyboard` in NUM_KEYS: raw key lines, active-high, asynchronous to `clock`.
- `enablen` in 1: active-low enable.
- `code` out CODE_W: last debounced key code; holds its value between presses.
- `valid` out 1: one-cycle strobe; `code` is valid in the same cycle.
- `held` out 1: high while a debounced key is down (PRESSED or RELEASE).
- `multi` out 1: high while two or more synchronised key bits are set.

## Operation
- Synchronise `keyboard` through a 2-flop synchroniser; call the output `ks`. The FSM sees only `ks`.
- Priority-encode `ks` as `pcode`: the highest set index wins. `nz` = (`ks` != 0).
- FSM states: IDLE, DEBOUNCE, PRESSED, RELEASE. 8-bit counter `cnt`.
- IDLE: if `nz` and `enablen`=0, go to DEBOUNCE, latch `cand`=`pcode`, and set `cnt`=1.
- DEBOUNCE:
  - `nz` and `pcode`==`cand`: increment `cnt`. When the incremented value reaches DEBOUNCE_CYCLES, go to PRESSED, load `code`=`cand` and pulse `valid`.
  - `nz` and `pcode`!=`cand`: restart with `cand`=`pcode` and `cnt`=1.
  - `!nz`: go to IDLE.
- DEBOUNCE_CYCLES=1 goes from IDLE directly to PRESSED, with `valid` on that transition.
- PRESSED: if `!nz`, go to RELEASE with `cnt`=1. A change of key while held is ignored; no new `valid`.
- RELEASE:
  - `!nz`: increment `cnt`; at DEBOUNCE_CYCLES go to IDLE.
  - `nz`: return to PRESSED with no `valid`.
- `enablen`=1 in any state: next state is IDLE, `valid`=0, `held` clears next cycle, and `code` is retained.
- `multi` is registered from `ks` every cycle, independent of state and `enablen`.
- Reset values: state IDLE, `cnt`=0, `code`=0, `valid`=0, `held`=0, `multi`=0, synchroniser flops 0.

## Timing
- Key asserted before edge E1. Edges E1/E2 fill the synchroniser. Edge E3 moves IDLE->DEBOUNCE (`cnt`=1).
- `valid` is high in the cycle after edge E(2+DEBOUNCE_CYCLES); with default 4, after E6. Latency = DEBOUNCE_CYCLES+2 edges.
- `held` rises in the same cycle as `valid` and falls in the cycle after release completes: DEBOUNCE_CYCLES+2 edges after the key drops.
- `valid` is never high for two consecutive cycles, except with REPEAT_PERIOD=1 under the repeat macro.
- `multi` lags `keyboard` by 3 edges.
- Reset asserted mid-press forces reset values immediately. After reset deasserts, a still-held key is debounced afresh and produces a new `valid`.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In PRESSED, an auto-repeat counter starts at PRESSED entry.
  - After REPEAT_DELAY cycles `valid` pulses, then again every REPEAT_PERIOD cycles, with `code` unchanged.
  - The counter resets on leaving PRESSED; RELEASE->PRESSED bounce restarts REPEAT_DELAY.
- Not defined: exactly one `valid` per debounced press; repeat logic and parameters are absent from the netlist.

## Test plan
- Reset, then `keyboard`=10'b0000001000 held 20 cycles, `enablen`=0 -> `valid` one cycle after E6, `code`=3, `held`=1. Release -> `held`=0 six edges later.
- Bounce: bit 5 toggles every 2 cycles for 10 cycles, then stays steady -> no `valid` during the bounce, single `valid` with `code`=5 after 4 stable samples.
- Two keys: `keyboard`=10'b1000000010 -> `multi`=1 after 3 edges; `valid` with `code`=9.
- `enablen`=1 with key 7 pressed -> no `valid`, `held`=0. Drop `enablen` to 0 mid-press -> `valid` `code`=7 after 4 stable samples.
- Reset asserted while PRESSED with `code`=2 -> all outputs 0 asynchronously. Key still held after deassert -> new `valid` `code`=2 at E6.
- With `KEYPAD_REPEAT_EN`, defaults, key 1 held 60 cycles -> first `valid` at E6, repeat `valid` pulses 32, 40, 48 and 56 cycles after PRESSED entry, all with `code`=1.
